// File: rtl/mips_isa_pkg.sv
// Shared MIPS encode definitions: mnemonics, opcodes, halt word, request payload.
package mips_isa_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned MNEM_W  = 5;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned TGT_W   = 26;

  typedef enum logic [MNEM_W-1:0] {
    R_TYPE = 5'd0,  ADDI  = 5'd1,  ADDIU = 5'd2,  ANDI  = 5'd3,
    XORI   = 5'd4,  ORI   = 5'd5,  BEQ   = 5'd6,  BNE   = 5'd7,
    BLEZ   = 5'd8,  BGTZ  = 5'd9,  LW    = 5'd10, SW    = 5'd11,
    LB     = 5'd12, SB    = 5'd13, SLTI  = 5'd14, LUI   = 5'd15,
    J      = 5'd16, JAL   = 5'd17, FTYPE = 5'd18, MTC1  = 5'd19,
    MFC1   = 5'd20
  } mnem_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ  = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ  = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_COP1  = 6'h11;
  localparam logic [OP_W-1:0] OP_LB    = 6'h20;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SB    = 6'h28;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [REG_W-1:0]  COP1_MT  = 5'd4;
  localparam logic [REG_W-1:0]  COP1_MF  = 5'd0;
  localparam logic [WORD_W-1:0] HALT_WORD = 32'h0000000C;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_HALT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Symbolic request fields (FTYPE reuses rs/rt/rd/shamt as fmt/ft/fs/fd)
  typedef struct packed {
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   shamt;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm;
    logic [TGT_W-1:0]   target;
  } inst_fields_t;

  // I-type word assembly
  function automatic logic [WORD_W-1:0] enc_i(input logic [OP_W-1:0] op,
                                              input logic [REG_W-1:0] rs,
                                              input logic [REG_W-1:0] rt,
                                              input logic [IMM_W-1:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/inst_word_encoder.sv
// Combinational mnemonic + fields -> 32-bit MIPS word, flags unknown mnemonics.
module inst_word_encoder
  import mips_isa_pkg::*;
(
  input  logic [MNEM_W-1:0] i_mnem,
  input  inst_fields_t      i_fields,
  output logic [WORD_W-1:0] o_word,
  output logic              o_illegal
);

  mnem_e w_mnem;
  assign w_mnem = mnem_e'(i_mnem);

  // Select the format and opcode for the mnemonic
  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (w_mnem)
      R_TYPE: o_word = {OP_RTYPE, i_fields.rs, i_fields.rt, i_fields.rd,
                        i_fields.shamt, i_fields.funct};
      ADDI:   o_word = enc_i(OP_ADDI,  i_fields.rs, i_fields.rt, i_fields.imm);
      ADDIU:  o_word = enc_i(OP_ADDIU, i_fields.rs, i_fields.rt, i_fields.imm);
      ANDI:   o_word = enc_i(OP_ANDI,  i_fields.rs, i_fields.rt, i_fields.imm);
      XORI:   o_word = enc_i(OP_XORI,  i_fields.rs, i_fields.rt, i_fields.imm);
      ORI:    o_word = enc_i(OP_ORI,   i_fields.rs, i_fields.rt, i_fields.imm);
      BEQ:    o_word = enc_i(OP_BEQ,   i_fields.rs, i_fields.rt, i_fields.imm);
      BNE:    o_word = enc_i(OP_BNE,   i_fields.rs, i_fields.rt, i_fields.imm);
      BLEZ:   o_word = enc_i(OP_BLEZ,  i_fields.rs, '0,          i_fields.imm);
      BGTZ:   o_word = enc_i(OP_BGTZ,  i_fields.rs, '0,          i_fields.imm);
      LW:     o_word = enc_i(OP_LW,    i_fields.rs, i_fields.rt, i_fields.imm);
      SW:     o_word = enc_i(OP_SW,    i_fields.rs, i_fields.rt, i_fields.imm);
      LB:     o_word = enc_i(OP_LB,    i_fields.rs, i_fields.rt, i_fields.imm);
      SB:     o_word = enc_i(OP_SB,    i_fields.rs, i_fields.rt, i_fields.imm);
      SLTI:   o_word = enc_i(OP_SLTI,  i_fields.rs, i_fields.rt, i_fields.imm);
      LUI:    o_word = enc_i(OP_LUI,   '0,          i_fields.rt, i_fields.imm);
      J:      o_word = {OP_J,   i_fields.target};
      JAL:    o_word = {OP_JAL, i_fields.target};
      FTYPE:  o_word = {OP_COP1, i_fields.rs, i_fields.rt, i_fields.rd,
                        i_fields.shamt, i_fields.funct};
      MTC1:   o_word = {OP_COP1, COP1_MT, i_fields.rt, i_fields.rd, 11'd0};
      MFC1:   o_word = {OP_COP1, COP1_MF, i_fields.rt, i_fields.rd, 11'd0};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Accepts symbolic instruction requests, writes encoded words sequentially
// into instruction memory and terminates every program with a halt word.
module inst_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [MNEM_W-1:0]   mnem,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    shamt,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [IMM_W-1:0]    imm,
  input  logic [TGT_W-1:0]    target,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic                done,
  output logic                err_illegal,
  output logic                err_overflow,
  output logic [ADDR_W:0]     count
);

  localparam int unsigned     CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_count;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_last;
  logic                r_in_ready;
  logic                r_we;
  logic                r_done;
  logic                r_err_ill;
  logic                r_err_ovf;

  inst_fields_t        w_fields;
  logic [WORD_W-1:0]   w_word;
  logic                w_illegal;
  logic                w_hs;
  logic                w_at_limit;
  logic                w_accept;
  logic                w_in_ready_nxt;
  logic                w_we_nxt;
  logic                w_done_nxt;

  assign w_fields.rs     = rs;
  assign w_fields.rt     = rt;
  assign w_fields.rd     = rd;
  assign w_fields.shamt  = shamt;
  assign w_fields.funct  = funct;
  assign w_fields.imm    = imm;
  assign w_fields.target = target;

  inst_word_encoder u_enc (
    .i_mnem    (mnem),
    .i_fields  (w_fields),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign w_hs       = in_valid & r_in_ready;
  assign w_at_limit = (r_addr == LAST_ADDR);
  assign w_accept   = w_hs & ~w_at_limit & ~w_illegal;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          if (w_at_limit)     w_state_nxt = ST_HALT;
          else if (w_illegal) w_state_nxt = in_last ? ST_HALT : ST_IDLE;
          else                w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: w_state_nxt = r_last ? ST_HALT : ST_IDLE;
      ST_HALT: w_state_nxt = ST_DONE;
      ST_DONE: if (start) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    w_in_ready_nxt = 1'b0;
    w_we_nxt       = 1'b0;
    w_done_nxt     = 1'b0;
    case (w_state_nxt)
      ST_IDLE: w_in_ready_nxt = 1'b1;
      ST_EMIT: w_we_nxt       = 1'b1;
      ST_HALT: w_we_nxt       = 1'b1;
      ST_DONE: w_done_nxt     = 1'b1;
      default: w_in_ready_nxt = 1'b0;
    endcase
  end

  // Registered outputs, address/count bookkeeping and sticky errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready <= 1'b1;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_count    <= '0;
      r_wdata    <= '0;
      r_last     <= 1'b0;
      r_err_ill  <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      r_we       <= w_we_nxt;
      r_done     <= w_done_nxt;

      if (w_state_nxt == ST_HALT)  r_wdata <= HALT_WORD;
      else if (w_accept)           r_wdata <= w_word;

      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            if (w_at_limit)     r_err_ovf <= 1'b1;
            else if (w_illegal) r_err_ill <= 1'b1;
            else                r_last    <= in_last;
          end
        end
        ST_EMIT: begin
          r_addr  <= r_addr + ADDR_W'(1);
          r_count <= r_count + CNT_W'(1);
        end
        ST_HALT: r_count <= r_count + CNT_W'(1);
        ST_DONE: begin
          if (start) begin
            r_addr  <= '0;
            r_count <= '0;
          end
        end
        default: r_last <= 1'b0;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign done         = r_done;
  assign err_illegal  = r_err_ill;
  assign err_overflow = r_err_ovf;
  assign count        = r_count;

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Encodes symbolic instruction requests (mnemonic plus fields) into 32-bit MIPS words and writes them sequentially into instruction memory. It is the encode-side counterpart of the control decoder and is used by benches and the boot path to build programs in place. A sequence ends with an automatic halt word, 32'h0000000C, which is the word the decoder recognises as halt.

Parameters:
ADDR_W, 8, instruction memory word-address width
DEPTH, 256, number of usable words; must be ≤ 2**ADDR_W and ≥ 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
start  in  1  from DONE: clear address and count, return to IDLE
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_last  in  1  request is the final instruction; halt word follows
mnem  in  5  mnemonic code (package enum)
rs, rt, rd, shamt  in  5 each  register and shift fields (FTYPE: fmt, ft, fs, fd)
funct  in  6  R/F function field
imm  in  16  I-type immediate
target  in  26  J-type target
imem_we  out  1  memory write strobe
imem_addr  out  ADDR_W  write word address
imem_wdata  out  32  encoded word
done  out  1  sequence complete, halt word written
err_illegal  out  1  sticky: illegal mnemonic seen
err_overflow  out  1  sticky: program truncated by depth
count  out  ADDR_W+1  words written, halt included

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; in_ready=1; imem_we=0; imem_addr=0; imem_wdata=0; done=0; both err=0; count=0. Reset dominates all inputs, including mid-EMIT; a pending write is dropped.
- FSM states: IDLE, EMIT, HALT, DONE.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) registers the encoded word, and the next state is EMIT.
- EMIT, one cycle: imem_we=1 at imem_addr. Next edge: addr+1, count+1. If the request had in_last=1, go to HALT; otherwise go to IDLE. Throughput is 1 word per 2 cycles. Latency is handshake edge N to write strobe in cycle N+1.
- HALT, one cycle: imem_we=1, wdata=32'h0000000C. Next edge: count+1, go to DONE.
- DONE: done=1, in_ready=0. start=1 goes to IDLE with addr=0 and count=0; err flags are kept. in_valid is ignored.
- Illegal mnemonic (codes 21–31): the request is accepted, no write occurs, err_illegal is set, and state stays IDLE. If in_last=1, go directly to HALT.
- Depth: the slot at DEPTH-1 is reserved for halt. A handshake while addr==DEPTH-1 sets err_overflow, drops the request, and goes to HALT, which guarantees termination.
- Encoding: {op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]} for R-type; {op, rs, rt, imm} for I-type; {op, target} for J-type.
  - R_TYPE: op=0, all fields used.
  - I-type ops: ADDI 08, ADDIU 09, SLTI 0A, ANDI 0C, ORI 0D, XORI 0E, LUI 0F (rs forced 0), BEQ 04, BNE 05, BLEZ 06 / BGTZ 07 (rt forced 0), LB 20, LW 23, SB 28, SW 2B.
  - J 02, JAL 03.
  - FTYPE: op=11, fields are passed through.
  - MTC1: op=11, rs=4, rt, rd, low 11 bits=0.
  - MFC1: op=11, rs=0, rt, rd, low 11 bits=0.
- Unused input fields are ignored. No field masking beyond the forced zeros above.

Decomposition:
- Package mips_isa_pkg holds:
  - the mnemonic enum (R_TYPE=0, ADDI=1, ADDIU=2, ANDI=3, XORI=4, ORI=5, BEQ=6, BNE=7, BLEZ=8, BGTZ=9, LW=10, SW=11, LB=12, SB=13, SLTI=14, LUI=15, J=16, JAL=17, FTYPE=18, MTC1=19, MFC1=20);
  - 6-bit opcode constants;
  - HALT_WORD=32'h0000000C.
- Sub-module inst_word_encoder is purely combinational: mnemonic and fields in, {word, illegal} out. The FSM, counters and error flags stay in the top module.

Test Plan:
- ADDI rs=1 rt=2 imm=0005, last=0 → one strobe with addr=0, wdata=20220005; count=1; in_ready returns to 1.
- J target=0000010 then MTC1 rt=3 rd=4 with last=1 → 08000010 @0, 44832000 @1, 0000000C @2; done=1; count=3.
- mnem=25 with last=1 → no instruction write; err_illegal=1; halt written @0; done; count=1.
- DEPTH=4: four back-to-back valid requests, last=0 → writes @0–2, fourth request dropped, err_overflow=1, halt @3, done=1.
- Reset asserted during EMIT → no strobe in the following cycles; all outputs at reset values; next ADDI is written at addr 0.
- From DONE, start=1 then BLEZ rs=5 rt=7 imm=FFFE with last=1 → 18A0FFFE @0 (rt forced 0), halt @1.
